// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller.
//   SEG_OFF     : segment bus value with every segment (and dp) dark
//   SEG_TABLE   : hex digit -> {1'b1, g..a} active-low segment patterns
//   scan_state_e: slot phase, BLANK during dead time, SHOW afterwards
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-segment decoder.
//   nibble : 4-bit hex value
//   seg_n  : {g..a}, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    logic [7:0] entry;

    always_comb begin
        entry = SEG_TABLE[nibble];
        seg_n = entry[6:0];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// A producer loads a display word into a pending buffer; it is copied into the
// active buffer only at a frame boundary, so a frame never mixes two words.
// Each digit slot starts with DEAD blanked cycles to suppress ghosting.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = scanning, 0 = display dark and scan position parked
//   load_*      : producer word offer (valid/ready), nibbles, dp, blank per digit
//   an          : anode selects, active-low
//   seg         : {dp,g..a}, active-low
//   frame_done  : one-cycle pulse after the last slot of a frame
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned DEAD   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic [DIGITS-1:0]     load_blank,
    output logic                  load_ready,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    scan_state_e         state_q, state_d;

    logic [4*DIGITS-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pend_valid_q, pend_valid_d;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end, boundary, accept, commit;
    logic [IDX_W+1:0]    nib_base;
    logic [3:0]          nib_sel;
    logic [6:0]          dec_seg;

    // Single decoder shared by all digits; it sees the digit under scan.
    assign nib_base = {idx_q, 2'b00};
    assign nib_sel  = act_data_q[nib_base +: 4];

    seg_hex_decode u_dec (
        .nibble (nib_sel),
        .seg_n  (dec_seg)
    );

    always_comb begin
        slot_end = (cnt_q == LAST_CNT);
        boundary = enable && slot_end && (idx_q == LAST_IDX);
        // Pending full and ready are complementary, so accept and commit never coincide.
        accept   = load_valid && !pend_valid_q;
        commit   = pend_valid_q && (boundary || !enable);

        cnt_d        = cnt_q;
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;

        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        state_d = (enable && (int'(cnt_d) >= int'(DEAD))) ? ST_SHOW : ST_BLANK;

        if (accept) begin
            pend_data_d  = load_data;
            pend_dp_d    = load_dp;
            pend_blank_d = load_blank;
            pend_valid_d = 1'b1;
        end
        if (commit) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end

        // Outputs lag the scan position by one cycle; enable gates them so the
        // display goes dark on the first cycle after enable drops.
        an_d         = '1;
        seg_d        = SEG_OFF;
        frame_done_d = boundary;
        if (enable && state_q == ST_SHOW) begin
            an_d[idx_q] = 1'b0;
            seg_d       = act_blank_q[idx_q] ? SEG_OFF : {~act_dp_q[idx_q], dec_seg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_BLANK;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = ~pend_valid_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
